imem_arbiter: RTL and testbench

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arb_pkg.sv | 6 +
 rtl/imem_rr_pick.sv | 13 +
 rtl/imem_arbiter.sv | 90 +++++++++
 tb/tb_imem_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/imem_arb_pkg.sv
// imem_arb_pkg: shared FSM state type and owner encodings for the instruction-memory arbiter
package imem_arb_pkg;
  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;
  localparam logic OWN_F = 1'b0;
  localparam logic OWN_D = 1'b1;
endpackage

// File: rtl/imem_rr_pick.sv
// imem_rr_pick: two-way round-robin pick between fetch and debug requesters
module imem_rr_pick
  import imem_arb_pkg::*;
(
  input  logic i_f_valid,
  input  logic i_d_valid,
  input  logic i_last,
  output logic o_win,
  output logic o_any
);
  assign o_any = i_f_valid | i_d_valid;
  assign o_win = (i_d_valid && (!i_f_valid || i_last == OWN_F)) ? OWN_D : OWN_F;
endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: arbitrates fetch and debug reads onto one instruction-memory port
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req_valid,
  input  logic [ADDR_W-1:0] f_req_addr,
  output logic              f_req_ready,
  output logic              f_rsp_valid,
  output logic [DATA_W-1:0] f_rsp_data,
  input  logic              f_rsp_ready,
  input  logic              d_req_valid,
  input  logic [ADDR_W-1:0] d_req_addr,
  output logic              d_req_ready,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rsp_data,
  input  logic              d_rsp_ready,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [CNT_W-1:0]  f_count,
  output logic [CNT_W-1:0]  d_count
);
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_owner, r_last;
  logic [CNT_W-1:0]  r_f_count, r_d_count;
  logic              w_win, w_any, w_accept, w_done;

  imem_rr_pick u_pick (
    .i_f_valid(f_req_valid),
    .i_d_valid(d_req_valid),
    .i_last   (r_last),
    .o_win    (w_win),
    .o_any    (w_any)
  );

  assign w_accept = (r_state == IDLE) && w_any;
  assign w_done   = (r_state == RESP) && (r_owner == OWN_F ? f_rsp_ready : d_rsp_ready);

  always_comb begin
    w_next = IDLE;
    if (r_state == IDLE && w_any) w_next = READ;
    else if (r_state == READ) w_next = RESP;
    else if (r_state == RESP && !w_done) w_next = RESP;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;

  // last-grant resets to debug so that fetch wins the first tie
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_addr    <= '0;
      r_owner   <= OWN_F;
      r_last    <= OWN_D;
      r_data    <= '0;
      r_f_count <= '0;
      r_d_count <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= (w_win == OWN_D) ? d_req_addr : f_req_addr;
        r_owner <= w_win;
        r_last  <= w_win;
      end
      if (r_state == READ) r_data <= mem_rdata;
      if (w_done && r_owner == OWN_F && r_f_count != '1) r_f_count <= r_f_count + CNT_W'(1);
      if (w_done && r_owner == OWN_D && r_d_count != '1) r_d_count <= r_d_count + CNT_W'(1);
    end

  assign f_req_ready = w_accept && (w_win == OWN_F);
  assign d_req_ready = w_accept && (w_win == OWN_D);
  assign f_rsp_valid = (r_state == RESP) && (r_owner == OWN_F);
  assign d_rsp_valid = (r_state == RESP) && (r_owner == OWN_D);
  assign f_rsp_data  = f_rsp_valid ? r_data : '0;
  assign d_rsp_data  = d_rsp_valid ? r_data : '0;
  assign mem_read    = (r_state == READ);
  assign mem_addr    = mem_read ? r_addr : '0;
  assign busy        = (r_state != IDLE);
  assign f_count     = r_f_count;
  assign d_count     = r_d_count;
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed scoreboard bench for the instruction-memory arbiter
module tb_imem_arbiter;
  logic        clk = 0, rst_n = 0;
  logic        f_req_valid = 0, d_req_valid = 0, f_rsp_ready = 0, d_rsp_ready = 0;
  logic [7:0]  f_req_addr = 0, d_req_addr = 0, mem_addr;
  logic        f_req_ready, f_rsp_valid, d_req_ready, d_rsp_valid, mem_read, busy;
  logic [31:0] f_rsp_data, d_rsp_data, mem_rdata;
  logic [1:0]  f_count, d_count;
  logic [31:0] mem [256];
  logic [32:0] exp_q [$];
  logic [32:0] mon_e;
  int          n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr];

  imem_arbiter #(.ADDR_W(8), .DATA_W(32), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req_valid(f_req_valid), .f_req_addr(f_req_addr), .f_req_ready(f_req_ready),
    .f_rsp_valid(f_rsp_valid), .f_rsp_data(f_rsp_data), .f_rsp_ready(f_rsp_ready),
    .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_ready(d_req_ready),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_ready(d_rsp_ready),
    .mem_read(mem_read), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .busy(busy), .f_count(f_count), .d_count(d_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_lo();
    rst_n = 0;
    #1;
    exp_q.delete();
  endtask

  task automatic rst_hi();
    tick();
    rst_n = 1;
  endtask

  task automatic wait_grant(output logic who, output logic ok);
    ok = 0;
    who = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (f_req_ready || d_req_ready) begin
        who = d_req_ready;
        ok = 1;
        return;
      end
      tick();
    end
    check("grant_timeout", {63'd0, f_req_ready | d_req_ready}, 1);
  endtask

  always @(negedge clk)
    if (rst_n && (f_rsp_valid || d_rsp_valid)) begin
      check("single_owner", {63'd0, f_rsp_valid & d_rsp_valid}, 0);
      if ((f_rsp_valid && f_rsp_ready) || (d_rsp_valid && d_rsp_ready)) begin
        check("sb_nonempty", {63'd0, exp_q.size() != 0}, 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("rsp_port_data", f_rsp_valid ? {1'b0, f_rsp_data} : {1'b1, d_rsp_data}, mon_e);
          check("nonowner_data", f_rsp_valid ? d_rsp_data : f_rsp_data, 0);
        end
      end
    end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic       who, ok;
    logic [3:0] order;
    int         dc [5];
    order = 4'b1010;
    dc = '{1, 2, 3, 3, 3};
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | i;
    mem[0] = 32'h20020020;
    mem[9] = 32'h08000002;
    #2;
    check("rst_busy", busy, 0);
    check("rst_f_ready", f_req_ready, 0);
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_rsp_valid", {f_rsp_valid, d_rsp_valid}, 0);
    check("rst_counts", {f_count, d_count}, 0);
    tick();
    rst_hi();
    f_req_valid = 1; f_req_addr = 0; f_rsp_ready = 1; d_rsp_ready = 1;
    #1;
    check("single_f_ready", f_req_ready, 1);
    check("single_d_ready", d_req_ready, 0);
    exp_q.push_back({1'b0, 32'h20020020});
    tick();
    f_req_valid = 0;
    check("read_mem_read", mem_read, 1);
    check("read_mem_addr", mem_addr, 0);
    check("read_no_ready", f_req_ready, 0);
    check("read_busy", busy, 1);
    tick();
    check("resp_f_valid", f_rsp_valid, 1);
    check("resp_mem_read", mem_read, 0);
    check("resp_d_valid", d_rsp_valid, 0);
    tick();
    check("single_f_count", f_count, 1);
    check("single_idle", busy, 0);
    rst_lo(); rst_hi();
    f_req_valid = 1; f_req_addr = 0; d_req_valid = 1; d_req_addr = 9;
    for (int i = 0; i < 4; i++) begin
      wait_grant(who, ok);
      if (ok) begin
        check("rr_order", who, order[i]);
        exp_q.push_back(who ? {1'b1, 32'h08000002} : {1'b0, 32'h20020020});
        tick();
      end
    end
    f_req_valid = 0; d_req_valid = 0;
    tick(); tick();
    check("rr_f_count", f_count, 2);
    check("rr_d_count", d_count, 2);
    rst_lo(); rst_hi();
    f_rsp_ready = 0; f_req_valid = 1; f_req_addr = 9; d_req_valid = 1; d_req_addr = 0;
    #1;
    check("stall_f_ready", f_req_ready, 1);
    check("stall_d_ready0", d_req_ready, 0);
    exp_q.push_back({1'b0, 32'h08000002});
    tick();
    f_req_valid = 0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", f_rsp_valid, 1);
      check("stall_data", f_rsp_data, 32'h08000002);
      check("stall_busy", busy, 1);
      check("stall_d_ready", d_req_ready, 0);
      tick();
    end
    f_rsp_ready = 1;
    tick();
    check("stall_idle", busy, 0);
    check("stall_d_wins", d_req_ready, 1);
    check("stall_f_count", f_count, 1);
    d_req_valid = 0;
    f_req_valid = 1; f_req_addr = 0;
    #1;
    check("pre_read_f_ready", f_req_ready, 1);
    tick();
    f_req_valid = 0;
    check("abort_read_active", mem_read, 1);
    rst_lo();
    check("abort_read_mem", {mem_read, mem_addr}, 0);
    check("abort_read_busy", busy, 0);
    check("abort_read_count", f_count, 0);
    rst_hi();
    f_rsp_ready = 0; f_req_valid = 1; d_req_valid = 1; f_req_addr = 0; d_req_addr = 9;
    #1;
    check("after_rst_f_wins", {f_req_ready, d_req_ready}, 2'b10);
    tick();
    f_req_valid = 0; d_req_valid = 0;
    tick();
    check("abort_resp_active", f_rsp_valid, 1);
    rst_lo();
    check("abort_resp_valid", f_rsp_valid, 0);
    check("abort_resp_data", f_rsp_data, 0);
    check("abort_resp_busy", busy, 0);
    check("abort_resp_count", f_count, 0);
    rst_hi();
    f_req_valid = 1; d_req_valid = 1;
    #1;
    check("after_rst2_f_wins", {f_req_ready, d_req_ready}, 2'b10);
    f_req_valid = 0; d_req_valid = 0; f_rsp_ready = 1;
    rst_lo(); rst_hi();
    d_req_valid = 1; d_req_addr = 9; d_rsp_ready = 1;
    for (int i = 0; i < 5; i++) begin
      wait_grant(who, ok);
      if (ok) begin
        check("dbg_grant", who, 1);
        exp_q.push_back({1'b1, 32'h08000002});
        tick(); tick(); tick();
        check("d_count_sat", d_count, dc[i]);
      end
    end
    d_req_valid = 0;
    tick();
    check("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
